y86_regfile_sb: RTL
===================

Name: y86_regfile_sb

Overview:
- Parametrised successor to the decode-stage register file for the pipelined Y86 core.
- Holds NREG architectural registers with two combinational read ports (srcA/srcB) and two clocked write ports (E and M).
- Adds a per-register busy scoreboard so decode can detect RAW hazards on in-flight destinations.
- Adds a pipeline write-enable, a configurable %rsp reset value, and an optional write-through bypass.

Parameters:
DATA_W, 64, register data width in bits
NREG, 15, number of architectural registers (IDs 0..NREG-1)
ID_W, 4, register-ID width; must satisfy 2^ID_W > NREG
RNONE, 4'hF, "no register" ID; reads return 0, writes are ignored, busy is never set
RSP_ID, 4, ID of %rsp
RSP_INIT, 64'h0, reset value of %rsp; all other registers reset to 0

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
srcA  in  ID_W  read port A register ID
srcB  in  ID_W  read port B register ID
valA  out  DATA_W  contents of srcA (combinational)
valB  out  DATA_W  contents of srcB (combinational)
srcA_busy  out  1  srcA has an outstanding write
srcB_busy  out  1  srcB has an outstanding write
dstE  in  ID_W  E-port write ID
valE  in  DATA_W  E-port write data
dstM  in  ID_W  M-port write ID
valM  in  DATA_W  M-port write data
wb_en  in  1  writeback enable; 0 = writeback bubble, no writes and no busy clears
iss_en  in  1  decode issue strobe
iss_dstE  in  ID_W  destination E of the issuing instruction
iss_dstM  in  ID_W  destination M of the issuing instruction
busy_mask  out  NREG  per-register busy bits, for debug
wr_count  out  16  total committed register writes, for debug

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers are 0, except register RSP_ID, which is RSP_INIT;
  - busy_mask is 0 and wr_count is 0;
  - reset applied mid-operation discards any in-flight write and busy state immediately.
- Read ports:
  - purely combinational, zero latency;
  - a srcX of RNONE, or any ID >= NREG, returns 0 and a busy flag of 0.
- Writes:
  - take effect at posedge clk when wb_en=1;
  - a port writes only if its dst != RNONE and dst < NREG;
  - both ports may write different registers in the same cycle;
  - if dstE == dstM (both valid), valM wins. This is the popq %rsp rule.
- Write latency: the new value is visible on valA/valB in the cycle after the edge (bypass excluded).
- wr_count:
  - increments by the number of distinct registers written that edge (0, 1 or 2);
  - dstE == dstM counts as 1;
  - wraps modulo 2^16.
- Scoreboard:
  - on posedge, each valid ID among iss_dstE/iss_dstM with iss_en=1 sets its busy bit;
  - each register written that edge clears its busy bit;
  - a set and a clear on the same register in the same edge: set wins, because a newer instruction now owns the register;
  - iss_en=0 sets nothing;
  - a clear of a register that is not busy has no effect.
- srcX_busy = busy_mask[srcX] when srcX is valid. It reflects the registered mask only and is not masked by a same-cycle writeback unless bypass is enabled.
- No FSM beyond the storage, scoreboard and counter. All outputs are defined every cycle; no X propagates from unwritten registers.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through forwarding.
  - If wb_en=1 and srcX matches a valid dstE/dstM in the current cycle, valX returns the incoming value, using the same M-over-E priority.
  - srcX_busy is 0 when that register is being cleared this cycle and not re-set by a simultaneous issue.
- Undefined: reads return only stored contents, and busy reflects the registered mask only.

Test Plan:
- Reset check: hold rst_n=0 with RSP_INIT=64'h100.
  - Required: valA=0 for srcA=0 and valB=0x100 for srcB=4, busy_mask=0, wr_count=0.
- Sequential writes: wb_en=1, dstE=3/valE=525, next cycle dstE=0/valE=300.
  - Required: srcA=3 reads 525, srcB=0 reads 300, wr_count=2.
- Dual-port collision: dstE=4/valE=999 and dstM=4/valM=777 in one cycle.
  - Required: reg 4 reads 777 and wr_count increments by 1.
- Scoreboard: iss_en=1, iss_dstE=2 in cycle n.
  - Required: srcA=2 gives srcA_busy=1 from cycle n+1.
  - A writeback dstE=2 in cycle n+3 clears the bit at n+4.
  - Issuing iss_dstE=2 on that same writeback edge leaves busy=1.
- Gating and RNONE: wb_en=0 with dstE=1/valE=55 leaves reg 1 unchanged; dstE=RNONE with wb_en=1 writes nothing; srcA=RNONE reads 0.
- Bypass (REGFILE_BYPASS_EN): dstM=5/valM=42 with srcA=5 in the same cycle.
  - Required: valA=42 combinationally.
  - Without the macro: old value until the next cycle.
- Async reset mid-write: drop rst_n between edges while reg 3=525 and busy_mask has bit 3 set.
  - Required: immediately reg 3=0, busy_mask=0.

Source files
------------

// File: rtl/y86_regfile_sb.sv
// Y86 decode-stage register file with per-register busy scoreboard and write counter.
// Optional write-through forwarding of the current writeback is enabled by defining REGFILE_BYPASS_EN.

module y86_regfile_sb_reg #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrEn,
  input  logic [DATA_W-1:0] wrData,
  input  logic              setBusy,
  output logic [DATA_W-1:0] value,
  output logic              busy
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= RESET_VAL;
      busy  <= 1'b0;
    end else begin
      if (wrEn) value <= wrData;
      // a newer issue to the same register outranks the retiring write
      busy <= setBusy | (busy & ~wrEn);
    end
  end
endmodule

module y86_regfile_sb #(
  parameter int                DATA_W   = 64,
  parameter int                NREG     = 15,
  parameter int                ID_W     = 4,
  parameter logic [ID_W-1:0]   RNONE    = 4'hF,
  parameter int                RSP_ID   = 4,
  parameter logic [DATA_W-1:0] RSP_INIT = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   srcA,
  input  logic [ID_W-1:0]   srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic              srcA_busy,
  output logic              srcB_busy,
  input  logic [ID_W-1:0]   dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [ID_W-1:0]   dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic              wb_en,
  input  logic              iss_en,
  input  logic [ID_W-1:0]   iss_dstE,
  input  logic [ID_W-1:0]   iss_dstM,
  output logic [NREG-1:0]   busy_mask,
  output logic [15:0]       wr_count
);

  function automatic logic idOk(input logic [ID_W-1:0] id);
    return (id != RNONE) && (32'(id) < 32'(NREG));
  endfunction

  logic                         vE, vM, issE, issM;
  logic [NREG-1:0]              wrE, wrM, wr, setB, busy;
  logic [NREG-1:0][DATA_W-1:0]  regVal;
  logic [1:0][ID_W-1:0]         rdSrc;
  logic [1:0][DATA_W-1:0]       rdVal;
  logic [1:0]                   rdBusy;

  assign vE   = wb_en  && idOk(dstE);
  assign vM   = wb_en  && idOk(dstM);
  assign issE = iss_en && idOk(iss_dstE);
  assign issM = iss_en && idOk(iss_dstM);

  for (genvar i = 0; i < NREG; i++) begin : gReg
    localparam logic [DATA_W-1:0] RV = (i == RSP_ID) ? RSP_INIT : '0;
    assign wrE[i]  = vE && (dstE == ID_W'(i));
    assign wrM[i]  = vM && (dstM == ID_W'(i));
    assign wr[i]   = wrE[i] | wrM[i];
    assign setB[i] = (issE && (iss_dstE == ID_W'(i))) || (issM && (iss_dstM == ID_W'(i)));

    // M beats E on a shared destination (popq %rsp)
    y86_regfile_sb_reg #(.DATA_W(DATA_W), .RESET_VAL(RV)) uReg (
      .clk     (clk),
      .rst_n   (rst_n),
      .wrEn    (wr[i]),
      .wrData  (wrM[i] ? valM : valE),
      .setBusy (setB[i]),
      .value   (regVal[i]),
      .busy    (busy[i])
    );
  end

  assign busy_mask = busy;

  // Read mux: only valid in-range IDs match, so RNONE/out-of-range read 0 and not busy
  assign rdSrc = {srcB, srcA};
  always_comb begin
    rdVal  = '0;
    rdBusy = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NREG; i++) begin
        if (idOk(rdSrc[p]) && rdSrc[p] == ID_W'(i)) begin
          rdVal[p]  = regVal[i];
          rdBusy[p] = busy[i];
`ifdef REGFILE_BYPASS_EN
          if (wr[i]) begin
            rdVal[p]  = wrM[i] ? valM : valE;
            rdBusy[p] = busy[i] & setB[i];
          end
`endif
        end
      end
    end
  end

  assign valA      = rdVal[0];
  assign valB      = rdVal[1];
  assign srcA_busy = rdBusy[0];
  assign srcB_busy = rdBusy[1];

  // counts distinct registers written, so a shared E/M destination adds one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_count <= '0;
    else        wr_count <= wr_count + 16'($countones(wr));
  end

endmodule
